// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA / CPU data-memory arbiter.
package vga_pkg;

  typedef enum logic [1:0] {IDLE, V_RD, C_RD, C_WR} arb_state_t;

  localparam int unsigned H_VIS     = 640;
  localparam int unsigned V_LAST    = 479;
  localparam int unsigned TILE_W    = 128;
  localparam int unsigned TILE_COLS = 5;
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 32;

  // Byte offset of a tile word inside the tile table.
  function automatic logic [7:0] tile_offset(input logic [2:0] row, input logic [2:0] col);
    return {row, col, 2'b00};
  endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Combinational next-tile address: the tile to the right, or column 0 of the
// next scanline's row when the current tile is the last one in the line.
module tile_addr_gen
  import vga_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0
) (
  input  logic [2:0]         col,
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  next_addr_c
);

  logic [2:0]         next_col;
  logic [2:0]         next_row;
  logic [COORD_W-1:0] y_inc;

  always_comb begin
    y_inc    = y + COORD_W'(1);
    next_col = 3'd0;
    next_row = 3'd0;
    if (col < 3'(TILE_COLS - 1)) begin
      next_col = col + 3'd1;
      next_row = y[8:6];
    end else begin
      // Last column wraps to the next line; the last visible line wraps to row 0.
      next_col = 3'd0;
      next_row = (y >= COORD_W'(V_LAST)) ? 3'd0 : 3'(y_inc >> 6);
    end
    next_addr_c = BASE_ADDR + ADDR_W'(tile_offset(next_row, next_col));
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Arbitrates the single data-memory port between CPU loads/stores and VGA
// tile prefetches, and swaps the prefetched tile word in at each tile boundary.
module vga_mem_arbiter
  import vga_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0,
  parameter logic [6:0]        LEAD      = 7'd16,
  parameter int unsigned       MEM_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pix_en,
  input  logic [COORD_W-1:0]  x,
  input  logic [COORD_W-1:0]  y,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_ack,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   pixel_word,
  output logic                underrun
);

  localparam logic [6:0] TRIG_POS = 7'(TILE_W - 32'(LEAD));
  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

  arb_state_t          state, state_d;
  logic [1:0]          lat_cnt, lat_cnt_d;
  logic                vga_need, vga_need_d;
  logic                next_ok, next_ok_d;
  logic [ADDR_W-1:0]   vga_addr, vga_addr_d;
  logic [DATA_W-1:0]   next_word, next_word_d;
  logic [DATA_W-1:0]   pixel_word_d;
  logic                underrun_d;
  logic                cpu_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_d;

  logic                visible_c;
  logic                trigger_c;
  logic                swap_c;
  logic [ADDR_W-1:0]   tile_addr_c;

  tile_addr_gen #(.BASE_ADDR(BASE_ADDR)) u_tile_addr_gen (
    .col         (x[9:7]),
    .y           (y),
    .next_addr_c (tile_addr_c)
  );

  assign visible_c = x < COORD_W'(H_VIS);
  assign trigger_c = pix_en && visible_c && (x[6:0] == TRIG_POS);
  assign swap_c    = pix_en && visible_c && (x[6:0] == 7'd0);

  always_comb begin
    state_d      = state;
    lat_cnt_d    = lat_cnt;
    vga_need_d   = vga_need;
    next_ok_d    = next_ok;
    vga_addr_d   = vga_addr;
    next_word_d  = next_word;
    pixel_word_d = pixel_word;
    underrun_d   = underrun;
    cpu_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata;
    mem_addr_d   = mem_addr;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata;

    case (state)
      IDLE: begin
        lat_cnt_d = 2'd0;
        if (vga_need) begin
          state_d    = V_RD;
          mem_addr_d = vga_addr;
        end else if (cpu_req && !cpu_ack) begin
          // The ack cycle still sees cpu_req high; it must not start a second access.
          mem_addr_d = cpu_addr;
          if (cpu_we) begin
            state_d     = C_WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = cpu_wdata;
          end else begin
            state_d = C_RD;
          end
        end
      end
      V_RD: begin
        if (lat_cnt == LAT_LAST) begin
          next_word_d = mem_rdata;
          next_ok_d   = 1'b1;
          vga_need_d  = 1'b0;
          state_d     = IDLE;
        end else begin
          lat_cnt_d = lat_cnt + 2'd1;
        end
      end
      C_WR: begin
        cpu_ack_d = 1'b1;
        state_d   = IDLE;
      end
      C_RD: begin
        if (lat_cnt == LAT_LAST) begin
          cpu_rdata_d = mem_rdata;
          cpu_ack_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          lat_cnt_d = lat_cnt + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new trigger overrides any completing fetch and restarts it on the new address.
    if (trigger_c) begin
      vga_need_d = 1'b1;
      next_ok_d  = 1'b0;
      vga_addr_d = tile_addr_c;
      if (state == V_RD || state_d == V_RD) begin
        state_d    = V_RD;
        lat_cnt_d  = 2'd0;
        mem_addr_d = tile_addr_c;
      end
    end

    if (swap_c) begin
      if (next_ok) pixel_word_d = next_word;
      else         underrun_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      lat_cnt    <= 2'd0;
      vga_need   <= 1'b1;
      next_ok    <= 1'b0;
      vga_addr   <= BASE_ADDR;
      next_word  <= '0;
      pixel_word <= '0;
      underrun   <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_d;
      lat_cnt    <= lat_cnt_d;
      vga_need   <= vga_need_d;
      next_ok    <= next_ok_d;
      vga_addr   <= vga_addr_d;
      next_word  <= next_word_d;
      pixel_word <= pixel_word_d;
      underrun   <= underrun_d;
      cpu_ack    <= cpu_ack_d;
      cpu_rdata  <= cpu_rdata_d;
      mem_addr   <= mem_addr_d;
      mem_we     <= mem_we_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

endmodule
